// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
// Module   : spi_pkg
// Brief    : Shared FSM state type, command encoding and frame-field helpers
//            for the SPI register-file peripheral.
// Revision : 1.0 - initial release
// ============================================================================
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } spi_state_e;

    localparam logic CMD_WRITE = 1'b1;

    // Frame layout, MSB first: R/W | address | data
    function automatic int frame_width(input int addr_w, input int data_w);
        return 1 + addr_w + data_w;
    endfunction

    function automatic int rw_pos(input int addr_w, input int data_w);
        return addr_w + data_w;
    endfunction

    function automatic int addr_lsb(input int data_w);
        return data_w;
    endfunction

    function automatic int hdr_bits(input int addr_w);
        return 1 + addr_w;
    endfunction

    // Counter must hold FRAME_W+1 so over-long frames stay distinguishable
    function automatic int cnt_width(input int addr_w, input int data_w);
        return $clog2(frame_width(addr_w, data_w) + 2);
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_sync_edge.sv
`default_nettype none
// ============================================================================
// Module   : spi_sync_edge
// Brief    : Two-flop synchroniser with one-clk rise/fall pulses derived from
//            a delayed copy of the synchronised level.
// Revision : 1.0 - initial release
// ============================================================================
module spi_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic async_i,
    output logic rise_o,
    output logic fall_o
);

    logic [1:0] sync_q;
    logic       dly_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b00;
            dly_q  <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], async_i};
            dly_q  <= sync_q[1];
        end
    end

    assign rise_o =  sync_q[1] & ~dly_q;
    assign fall_o = ~sync_q[1] &  dly_q;

endmodule
`default_nettype wire

// File: rtl/spi_regfile_peripheral.sv
`default_nettype none
// ============================================================================
// Module   : spi_regfile_peripheral
// Brief    : SPI target owning a small register file; write frames update a
//            register, read frames return one on CIPO when SPI_READBACK_EN is
//            defined.
// Revision : 1.0 - initial release
// ============================================================================
module spi_regfile_peripheral
    import spi_pkg::*;
#(
    parameter int NUM_REGS = 5,
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 7,
    parameter int CPOL     = 0,
    parameter int CPHA     = 0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       sclk,
    input  logic                       copi,
    input  logic                       ncs,
    output logic                       cipo,
    output logic                       cipo_oe,
    output logic [NUM_REGS*DATA_W-1:0] regs_flat,
    output logic                       wr_valid,
    output logic [ADDR_W-1:0]          wr_addr,
    output logic                       frame_err
);

    localparam int FRAME_W  = frame_width(ADDR_W, DATA_W);
    localparam int CNT_W    = cnt_width(ADDR_W, DATA_W);
    localparam int RW_POS   = rw_pos(ADDR_W, DATA_W);
    localparam int ADDR_LSB = addr_lsb(DATA_W);

    localparam logic [CNT_W-1:0]  CNT_FULL   = CNT_W'(FRAME_W);
    localparam logic [CNT_W-1:0]  CNT_SAT    = CNT_W'(FRAME_W + 1);
    localparam logic [ADDR_W:0]   NUM_REGS_L = (ADDR_W + 1)'(NUM_REGS);

    logic sclk_rise, sclk_fall, ncs_rise, ncs_fall;
    logic [1:0] copi_sync_q;
    logic sample_edge;

    spi_sync_edge u_sclk_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .async_i (sclk),
        .rise_o  (sclk_rise),
        .fall_o  (sclk_fall)
    );

    spi_sync_edge u_ncs_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .async_i (ncs),
        .rise_o  (ncs_rise),
        .fall_o  (ncs_fall)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) copi_sync_q <= 2'b00;
        else        copi_sync_q <= {copi_sync_q[0], copi};
    end

    assign sample_edge = (CPOL == CPHA) ? sclk_rise : sclk_fall;

    spi_state_e          state_q;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [FRAME_W-1:0]  shift_q, shift_d;
    logic [DATA_W-1:0]   regs_q [NUM_REGS];
    logic                wr_valid_q, frame_err_q;
    logic [ADDR_W-1:0]   wr_addr_q;

    logic                rw_bit;
    logic [ADDR_W-1:0]   addr_f;
    logic [DATA_W-1:0]   data_f;
    logic                addr_ok, commit_wr;

    always_comb begin
        shift_d   = {shift_q[FRAME_W-2:0], copi_sync_q[1]};
        cnt_d     = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + CNT_W'(1);
        rw_bit    = shift_q[RW_POS];
        addr_f    = shift_q[ADDR_LSB +: ADDR_W];
        data_f    = shift_q[DATA_W-1:0];
        addr_ok   = {1'b0, addr_f} < NUM_REGS_L;
        commit_wr = (state_q == COMMIT) && (cnt_q == CNT_FULL) &&
                    (rw_bit == CMD_WRITE) && addr_ok;
    end

    // A ncs rise outranks any sclk edge detected in the same clk
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            shift_q     <= '0;
            wr_valid_q  <= 1'b0;
            wr_addr_q   <= '0;
            frame_err_q <= 1'b0;
        end else begin
            wr_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (ncs_fall) begin
                        cnt_q   <= '0;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (ncs_rise) begin
                        state_q <= COMMIT;
                    end else if (sample_edge) begin
                        shift_q <= shift_d;
                        cnt_q   <= cnt_d;
                    end
                end
                COMMIT: begin
                    state_q <= IDLE;
                    if (cnt_q != CNT_FULL) begin
                        frame_err_q <= 1'b1;
                    end else if (commit_wr) begin
                        wr_valid_q <= 1'b1;
                        wr_addr_q  <= addr_f;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NUM_REGS; r++) regs_q[r] <= '0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                if (commit_wr && (addr_f == ADDR_W'(r))) regs_q[r] <= data_f;
            end
        end
    end

    generate
        for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
            assign regs_flat[g*DATA_W +: DATA_W] = regs_q[g];
        end
    endgenerate

    assign wr_valid  = wr_valid_q;
    assign wr_addr   = wr_addr_q;
    assign frame_err = frame_err_q;

`ifdef SPI_READBACK_EN
    localparam logic [CNT_W-1:0] CNT_HDR = CNT_W'(hdr_bits(ADDR_W));

    logic              drive_edge, rd_load;
    logic [DATA_W-1:0] out_sh_q, rd_data;
    logic              cipo_q, cipo_oe_q;

    assign drive_edge = (CPOL == CPHA) ? sclk_fall : sclk_rise;

    // The header is complete once the counter reaches 1+ADDR_W; its R/W and
    // address now sit in the low bits of the freshly shifted word.
    always_comb begin
        rd_data = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            if (shift_d[ADDR_W-1:0] == ADDR_W'(r)) rd_data = regs_q[r];
        end
        rd_load = (state_q == SHIFT) && !ncs_rise && sample_edge &&
                  (cnt_d == CNT_HDR) && (shift_d[ADDR_W] != CMD_WRITE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_sh_q  <= '0;
            cipo_q    <= 1'b0;
            cipo_oe_q <= 1'b0;
        end else if ((state_q != SHIFT) || ncs_rise) begin
            cipo_q    <= 1'b0;
            cipo_oe_q <= 1'b0;
        end else if (rd_load) begin
            out_sh_q  <= rd_data;
            cipo_oe_q <= 1'b1;
        end else if (drive_edge && cipo_oe_q) begin
            cipo_q   <= out_sh_q[DATA_W-1];
            out_sh_q <= {out_sh_q[DATA_W-2:0], 1'b0};
        end
    end

    assign cipo    = cipo_q;
    assign cipo_oe = cipo_oe_q;
`else
    assign cipo    = 1'b0;
    assign cipo_oe = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_spi_regfile_peripheral.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_regfile_peripheral
// Brief    : Drives a mode-0 and a mode-3 instance with directed and random
//            frames and checks them against a frame-level register model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_regfile_peripheral;

    localparam int NR = 5;
    localparam int H  = 6;
`ifdef SPI_READBACK_EN
    localparam bit RB = 1'b1;
`else
    localparam bit RB = 1'b0;
`endif

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic [1:0]  sclk  = 2'b10;
    logic [1:0]  copi  = 2'b00;
    logic [1:0]  ncs   = 2'b11;
    logic [1:0]  cipo, cipo_oe, wr_valid, frame_err;
    logic [39:0] regs_flat [2];
    logic [6:0]  wr_addr [2];

    spi_regfile_peripheral #(.NUM_REGS(5), .DATA_W(8), .ADDR_W(7), .CPOL(0), .CPHA(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .sclk(sclk[0]), .copi(copi[0]), .ncs(ncs[0]),
        .cipo(cipo[0]), .cipo_oe(cipo_oe[0]), .regs_flat(regs_flat[0]),
        .wr_valid(wr_valid[0]), .wr_addr(wr_addr[0]), .frame_err(frame_err[0])
    );

    spi_regfile_peripheral #(.NUM_REGS(5), .DATA_W(8), .ADDR_W(7), .CPOL(1), .CPHA(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .sclk(sclk[1]), .copi(copi[1]), .ncs(ncs[1]),
        .cipo(cipo[1]), .cipo_oe(cipo_oe[1]), .regs_flat(regs_flat[1]),
        .wr_valid(wr_valid[1]), .wr_addr(wr_addr[1]), .frame_err(frame_err[1])
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Frame-level model: register contents, last write address and the
    // pulses a just-finished frame must produce within 4 clk of ncs rising.
    logic [7:0]  mregs [2][NR];
    logic [6:0]  maddr [2];
    logic [39:0] old_flat [2];
    int          win [2];
    int          exp_wv [2], exp_err [2], seen_wv [2], seen_err [2];
    bit          busy [2];

    task automatic chk(input bit ok, input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [39:0] flat(input int m);
        logic [39:0] f;
        f = '0;
        for (int r = 0; r < NR; r++) f[r*8 +: 8] = mregs[m][r];
        return f;
    endfunction

    task automatic waitn(input int k);
        repeat (k) @(negedge clk);
    endtask

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            for (int r = 0; r < NR; r++) mregs[m][r] = 8'h00;
            maddr[m] = '0;
            win[m]   = 0;
            busy[m]  = 1'b0;
        end
    endtask

    task automatic open_window(input int m, input int wv, input int er);
        exp_wv[m]   = wv;
        exp_err[m]  = er;
        seen_wv[m]  = 0;
        seen_err[m] = 0;
        win[m]      = 4;
        busy[m]     = 1'b0;
    endtask

    // Only a 16-bit frame counts; its first 16 bits are R/W, address, data.
    task automatic end_model(input int m, input logic [31:0] bits, input int n, input bit simul);
        int          nb;
        logic [15:0] f;
        int          wv;
        nb = simul ? n - 1 : n;
        f  = 16'(bits >> (n - 16));
        wv = 0;
        old_flat[m] = flat(m);
        if (nb == 16 && f[15] && int'(f[14:8]) < NR) begin
            mregs[m][int'(f[14:8])] = f[7:0];
            maddr[m] = f[14:8];
            wv = 1;
        end
        open_window(m, wv, (nb != 16) ? 1 : 0);
    endtask

    task automatic frame(input int m, input logic [31:0] bits, input int n,
                         input bit simul, input int abort_at, output logic [7:0] rd);
        logic       rw0, idle, ec;
        logic [6:0] ad;
        logic [7:0] ed;
        bit         eoe;
        rd   = 8'h00;
        rw0  = bits[n-1];
        ad   = bits[n-2 -: 7];
        idle = (m == 1);
        ed   = (RB && int'(ad) < NR) ? mregs[m][int'(ad)] : 8'h00;
        ncs[m]  = 1'b0;
        busy[m] = 1'b1;
        waitn(H);
        for (int i = 0; i < n; i++) begin
            if (abort_at > 0 && i == abort_at) begin
                rst_n = 1'b0;
                model_reset();
                waitn(3);
                rst_n = 1'b1;
                waitn(3);
                sclk[m] = idle;
                ncs[m]  = 1'b1;
                old_flat[m] = flat(m);
                open_window(m, 0, 0);
                waitn(2*H);
                return;
            end
            if (m == 1) sclk[m] = ~sclk[m];
            copi[m] = bits[n-1-i];
            waitn(H);
            if (i < 16) begin
                eoe = RB && !rw0 && (i >= 8);
                ec  = eoe ? ed[15-i] : 1'b0;
                if (i >= 8) rd[15-i] = cipo[m];
                chk(cipo_oe[m] == eoe, "cipo_oe_bit", 64'(cipo_oe[m]), 64'(eoe));
                chk(cipo[m] == ec, "cipo_bit", 64'(cipo[m]), 64'(ec));
            end
            if (simul && i == n-1) begin
                sclk[m] = ~sclk[m];
                ncs[m]  = 1'b1;
                end_model(m, bits, n, simul);
                waitn(H);
                sclk[m] = idle;
                waitn(2*H);
                return;
            end
            sclk[m] = ~sclk[m];
            waitn(H);
            if (m == 0) sclk[m] = ~sclk[m];
        end
        ncs[m] = 1'b1;
        end_model(m, bits, n, 1'b0);
        waitn(2*H);
    endtask

    // Per-cycle comparison against the model, sampled 1 time unit after posedge
    always begin
        @(posedge clk);
        #1;
        for (int m = 0; m < 2; m++) begin
            if (win[m] > 0) begin
                if (wr_valid[m]) begin
                    seen_wv[m]++;
                    chk(regs_flat[m] == flat(m), "wv_coincident", 64'(regs_flat[m]), 64'(flat(m)));
                    chk(wr_addr[m] == maddr[m], "wv_addr", 64'(wr_addr[m]), 64'(maddr[m]));
                end
                if (frame_err[m]) seen_err[m]++;
                chk(regs_flat[m] == flat(m) || regs_flat[m] == old_flat[m], "regs_window",
                    64'(regs_flat[m]), 64'(flat(m)));
                win[m]--;
                if (win[m] == 0) begin
                    chk(seen_wv[m] == exp_wv[m], "wr_valid_count", 64'(seen_wv[m]), 64'(exp_wv[m]));
                    chk(seen_err[m] == exp_err[m], "frame_err_count", 64'(seen_err[m]), 64'(exp_err[m]));
                    chk(regs_flat[m] == flat(m), "regs_final", 64'(regs_flat[m]), 64'(flat(m)));
                    chk(wr_addr[m] == maddr[m], "wr_addr_final", 64'(wr_addr[m]), 64'(maddr[m]));
                end
            end else begin
                chk(regs_flat[m] == flat(m), "regs", 64'(regs_flat[m]), 64'(flat(m)));
                chk(wr_valid[m] == 1'b0, "wr_valid_idle", 64'(wr_valid[m]), 64'h0);
                chk(frame_err[m] == 1'b0, "frame_err_idle", 64'(frame_err[m]), 64'h0);
                chk(wr_addr[m] == maddr[m], "wr_addr", 64'(wr_addr[m]), 64'(maddr[m]));
                if (!busy[m]) begin
                    chk(cipo_oe[m] == 1'b0, "cipo_oe_idle", 64'(cipo_oe[m]), 64'h0);
                    chk(cipo[m] == 1'b0, "cipo_idle", 64'(cipo[m]), 64'h0);
                end
            end
        end
    end

    initial begin
        logic [7:0]  rd;
        logic [31:0] bits;
        int          n, m;
        logic        rw;
        logic [6:0]  ad;
        logic [7:0]  dt;

        model_reset();
        #2 rst_n = 1'b0;
        waitn(4);
        chk(regs_flat[0] == 40'h0 && regs_flat[1] == 40'h0, "reset_regs", 64'(regs_flat[0]), 64'h0);
        chk(wr_addr[0] == 7'h0 && cipo_oe == 2'b00 && cipo == 2'b00, "reset_out",
            64'({wr_addr[0], cipo_oe, cipo}), 64'h0);
        rst_n = 1'b1;
        waitn(4);

        frame(0, 32'h81A5, 16, 1'b0, 0, rd);
        chk(regs_flat[0] == 40'h00_00_00_A5_00, "lit_write_a5", 64'(regs_flat[0]), 64'h00000000A500);
        chk(wr_addr[0] == 7'd1, "lit_wr_addr1", 64'(wr_addr[0]), 64'd1);

        frame(0, 32'h873C, 16, 1'b0, 0, rd);
        chk(regs_flat[0] == 40'h00_00_00_A5_00, "lit_addr7_nowrite", 64'(regs_flat[0]), 64'h00000000A500);

        frame(0, 32'hABC, 12, 1'b0, 0, rd);
        frame(0, 32'h10A5A, 17, 1'b0, 0, rd);
        chk(regs_flat[0] == 40'h00_00_00_A5_00, "lit_badlen_noeffect", 64'(regs_flat[0]), 64'h00000000A500);

        frame(1, 32'h8455, 16, 1'b0, 0, rd);
        chk(regs_flat[1] == 40'h55_00_00_00_00, "lit_mode3_write", 64'(regs_flat[1]), 64'h5500000000);
        frame(1, 32'h0400, 16, 1'b0, 0, rd);
        chk(rd == (RB ? 8'h55 : 8'h00), "lit_mode3_read", 64'(rd), RB ? 64'h55 : 64'h00);

        frame(0, 32'h8277, 16, 1'b0, 8, rd);
        chk(regs_flat[0] == 40'h0 && regs_flat[1] == 40'h0, "lit_abort_regs", 64'(regs_flat[0]), 64'h0);
        frame(0, 32'h8277, 16, 1'b0, 0, rd);
        chk(regs_flat[0] == 40'h00_00_77_00_00, "lit_after_abort", 64'(regs_flat[0]), 64'h0000770000);

        frame(0, 32'h8399, 16, 1'b1, 0, rd);
        chk(regs_flat[0] == 40'h00_00_77_00_00, "lit_simul_drop", 64'(regs_flat[0]), 64'h0000770000);

        for (int k = 0; k < 60; k++) begin
            m  = k % 2;
            rw = 1'($urandom_range(0, 1));
            ad = 7'($urandom_range(0, 7));
            dt = 8'($urandom);
            n  = ($urandom_range(0, 4) == 0) ? int'($urandom_range(12, 18)) : 16;
            bits = (n == 16) ? {16'h0, rw, ad, dt} : ({rw, ad, dt, 16'h0} >> (32 - n));
            frame(m, bits, n, 1'b0, 0, rd);
        end

        waitn(10);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
